lzc_pipe: RTL

- Pipelined, parametrised leading/trailing match counter.
- Produces three results per input vector:
  - the one-hot position of the first matching bit;
  - its binary count (the number of non-matching bits scanned before it);
  - a "no match" flag.
- Scan direction (from MSB or from LSB) and match polarity (first 0 or first 1) are chosen per transaction at run time, not fixed at elaboration.
- Sits between operand-staging logic and normaliser/shifter or allocator logic. Valid/ready handshake on both sides, fixed 2-cycle latency, full throughput.

---
 rtl/lzc_pkg.sv | 20 ++
 rtl/pri.sv | 23 ++
 rtl/lzc_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lzc_pkg.sv
// rtl/lzc_pkg.sv - shared helpers for the leading/trailing match counter
package lzc_pkg;

  // Widest vector the bit-reverse helper can handle; lzc_pipe refuses anything wider.
  localparam int unsigned MAX_W = 1024;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] x, input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(w)) r[int'(w) - 1 - i] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pri.sv
// rtl/pri.sv - one-hot priority picker, first set bit from the MSB (or LSB)
module pri #(
  parameter int W        = 8,
  parameter bit FROM_LSB = 1'b0
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_oh
);

  logic found;

  always_comb begin
    o_oh  = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!found && i_x[FROM_LSB ? i : W - 1 - i]) begin
        o_oh[FROM_LSB ? i : W - 1 - i] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzc_pipe.sv
// rtl/lzc_pipe.sv - two-stage pipelined first-match finder with run-time direction/polarity
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int W     = 64,
  parameter int SEG_W = 8,
  parameter int TAG_W = 4,
  localparam int CW   = cnt_width(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W-1:0]     i_x,
  input  logic             i_from_lsb,
  input  logic             i_detect_zero,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_y,
  output logic [CW-1:0]    o_cnt,
  output logic             o_none,
  output logic [TAG_W-1:0] o_tag
);

  localparam int NS = (SEG_W > 0) ? W / SEG_W : 1;
  localparam int IW = (SEG_W > 1) ? $clog2(SEG_W) : 1;

  if (W < 2 || SEG_W < 1 || (W % SEG_W) != 0 || W > int'(MAX_W)) begin : g_bad_param
    $error("lzc_pipe: W must be >= 2 and a multiple of SEG_W");
  end

  typedef struct packed {
    logic [NS-1:0]            any;
    logic [NS-1:0][SEG_W-1:0] loc_oh;
    logic [NS-1:0][IW-1:0]    loc_idx;
    logic                     from_lsb;
    logic [TAG_W-1:0]         tag;
  } s1_rec_t;

  // Offset counted from the segment MSB, matching the scan order.
  function automatic logic [IW-1:0] oh_to_off(input logic [SEG_W-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int j = 0; j < SEG_W; j++) begin
      if (oh[j]) r = r | IW'(SEG_W - 1 - j);
    end
    return r;
  endfunction

  logic                     s1_valid_q, s1_valid_d;
  logic                     s2_valid_q, s2_valid_d;
  s1_rec_t                  s1_q, s1_d, s1_new;
  logic [W-1:0]             y_q, y_d, y_new, y_norm;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_new;
  logic                     none_q, none_d, none_new;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [W-1:0]             x_n;
  logic [NS-1:0][SEG_W-1:0] seg_oh;
  logic [NS-1:0]            any_msb, sel_oh;
  logic                     s1_advance, in_fire, s2_load;

  // Fold polarity and direction away so the core only ever looks for the first 1 from the MSB.
  always_comb begin
    x_n = i_x ^ {W{i_detect_zero}};
    if (i_from_lsb) x_n = W'(bit_rev(MAX_W'(x_n), W));
  end

  for (genvar s = 0; s < NS; s++) begin : g_seg
    pri #(.W(SEG_W), .FROM_LSB(1'b0)) u_pri (
      .i_x  (x_n[W - 1 - s * SEG_W -: SEG_W]),
      .o_oh (seg_oh[s])
    );
    assign any_msb[NS - 1 - s] = s1_q.any[s];
  end

  always_comb begin
    s1_new          = '0;
    s1_new.from_lsb = i_from_lsb;
    s1_new.tag      = i_tag;
    for (int s = 0; s < NS; s++) begin
      s1_new.any[s]     = |seg_oh[s];
      s1_new.loc_oh[s]  = seg_oh[s];
      s1_new.loc_idx[s] = oh_to_off(seg_oh[s]);
    end
  end

  pri #(.W(NS), .FROM_LSB(1'b0)) u_sel (
    .i_x  (any_msb),
    .o_oh (sel_oh)
  );

  always_comb begin
    y_norm  = '0;
    cnt_new = '0;
    for (int s = 0; s < NS; s++) begin
      if (sel_oh[NS - 1 - s]) begin
        y_norm[W - 1 - s * SEG_W -: SEG_W] = s1_q.loc_oh[s];
        cnt_new = CW'(s * SEG_W) + CW'(s1_q.loc_idx[s]);
      end
    end
    none_new = ~|s1_q.any;
    if (none_new) cnt_new = CW'(W);
    y_new = s1_q.from_lsb ? W'(bit_rev(MAX_W'(y_norm), W)) : y_norm;
  end

  assign s1_advance = !s2_valid_q | i_ready;
  assign o_ready    = !s1_valid_q | s1_advance;
  assign in_fire    = i_valid & o_ready;
  assign s2_load    = s1_valid_q & s1_advance;

  always_comb begin
    s1_valid_d = o_ready ? in_fire : s1_valid_q;
    s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;
    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
    s1_d   = in_fire ? s1_new : s1_q;
    y_d    = s2_load ? y_new : y_q;
    cnt_d  = s2_load ? cnt_new : cnt_q;
    none_d = s2_load ? none_new : none_q;
    tag_d  = s2_load ? s1_q.tag : tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      cnt_q      <= '0;
      none_q     <= 1'b0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      none_q     <= none_d;
      tag_q      <= tag_d;
    end
  end

  // Stage-1 record is only meaningful under s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign o_valid = s2_valid_q;
  assign o_y     = y_q;
  assign o_cnt   = cnt_q;
  assign o_none  = none_q;
  assign o_tag   = tag_q;

endmodule
